// File: rtl/conv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : conv_pkg
// Description : Shared definitions for the UART convolution frame sequencer.
//               Provides the FSM state encoding, default geometry
//               and the expected number of valid windows per frame.
// Revision    : 1.0 - initial release
// ============================================================================
package conv_pkg;

    // State encodings are visible on the state port (LEDs/debug).
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_KERNEL = 3'd1,
        ST_PIXEL  = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_DONE   = 3'd4
    } conv_state_e;

    localparam int unsigned CONV_IMG_W    = 502;
    localparam int unsigned CONV_IMG_H    = 502;
    localparam int unsigned CONV_K        = 3;
    localparam int unsigned CONV_IDLE_CYC = 16;

    // Number of KxK windows fully inside a WxH image.
    function automatic int unsigned conv_out_cnt(input int unsigned w,
                                                 input int unsigned h,
                                                 input int unsigned k);
        return (w - k + 1) * (h - k + 1);
    endfunction

    localparam int unsigned CONV_OUT_CNT = conv_out_cnt(CONV_IMG_W, CONV_IMG_H, CONV_K);

endpackage
`default_nettype wire

// File: rtl/conv_pos_tracker.sv
`default_nettype none
// ============================================================================
// Module      : conv_pos_tracker
// Description : Row/column position of the pixel currently being received.
//               Flags whether that pixel closes a KxK window fully inside
//               the image, and whether it is the last pixel of the frame.
// Ports       : clk, rst      - clock, asynchronous active-high reset
//               advance       - one accepted pixel (advances position)
//               win_valid     - current (pre-increment) position closes a
//                               complete window
//               last_pix      - current position is the final pixel
// Revision    : 1.0 - initial release
// ============================================================================
module conv_pos_tracker
    import conv_pkg::*;
#(
    parameter int unsigned IMG_W = CONV_IMG_W,
    parameter int unsigned IMG_H = CONV_IMG_H,
    parameter int unsigned K     = CONV_K
) (
    input  logic clk,
    input  logic rst,
    input  logic advance,
    output logic win_valid,
    output logic last_pix
);

    localparam int unsigned COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int unsigned ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    localparam logic [COL_W-1:0] c_col_last = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] c_row_last = ROW_W'(IMG_H - 1);

    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q <= '0;
            row_q <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end

    // Raster-order advance; the final pixel wraps both counters back to 0.
    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (advance) begin
            if (col_q == c_col_last) begin
                col_d = '0;
                row_d = (row_q == c_row_last) ? '0 : row_q + ROW_W'(1);
            end else begin
                col_d = col_q + COL_W'(1);
            end
        end
    end

    assign last_pix = (row_q == c_row_last) && (col_q == c_col_last);

    // With a 1x1 kernel every pixel is its own complete window.
    if (K == 1) begin : g_k1
        assign win_valid = 1'b1;
    end else begin : g_kn
        localparam logic [COL_W-1:0] c_col_min = COL_W'(K - 1);
        localparam logic [ROW_W-1:0] c_row_min = ROW_W'(K - 1);
        assign win_valid = (row_q >= c_row_min) && (col_q >= c_col_min);
    end

endmodule
`default_nettype wire

// File: rtl/conv_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : conv_frame_ctrl
// Description : Frame sequencer for the UART convolution datapath. Arms on
//               an idle rx line, enables kernel then pixel reception,
//               strobes the calculator per pixel and the sender only for
//               windows fully inside the image, then drains and reports
//               completion. Flags strobes issued while the sender is busy.
// Ports       : clk, rst     - clock, asynchronous active-high reset
//               rx           - raw UART line (idle detection only)
//               kernel_done  - all kernel coefficients received
//               pix_valid    - new pixel byte pulse
//               send_busy    - sender has a byte in flight
//               kernel_we    - kernel receiver enable
//               pixel_we     - pixel receiver enable
//               cal_we       - shift/calc strobe (combinational)
//               send_we      - sender strobe, one cycle per valid window
//               frame_done   - sticky frame-complete flag
//               overrun      - sticky: send_we seen while send_busy
//               state        - FSM state for LEDs/debug
// Revision    : 1.0 - initial release
// ============================================================================
module conv_frame_ctrl
    import conv_pkg::*;
#(
    parameter int unsigned IMG_W    = CONV_IMG_W,
    parameter int unsigned IMG_H    = CONV_IMG_H,
    parameter int unsigned K        = CONV_K,
    parameter int unsigned IDLE_CYC = CONV_IDLE_CYC
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    input  logic       kernel_done,
    input  logic       pix_valid,
    input  logic       send_busy,
    output logic       kernel_we,
    output logic       pixel_we,
    output logic       cal_we,
    output logic       send_we,
    output logic       frame_done,
    output logic       overrun,
    output logic [2:0] state
);

    localparam int unsigned IDLE_W = (IDLE_CYC > 1) ? $clog2(IDLE_CYC) : 1;
    localparam logic [IDLE_W-1:0] c_idle_last = IDLE_W'(IDLE_CYC - 1);

    conv_state_e       state_q, state_d;
    logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;
    logic              kernel_we_q, kernel_we_d;
    logic              pixel_we_q, pixel_we_d;
    logic              send_we_q, send_we_d;
    logic              frame_done_q, frame_done_d;
    logic              overrun_q, overrun_d;
    logic [31:0]       out_cnt_q, out_cnt_d;

    logic pix_accept;
    logic win_valid;
    logic last_pix;

    // Pixels are only counted while the pixel receiver is enabled.
    assign pix_accept = pix_valid && (state_q == ST_PIXEL);

    conv_pos_tracker #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H),
        .K     (K)
    ) u_pos (
        .clk       (clk),
        .rst       (rst),
        .advance   (pix_accept),
        .win_valid (win_valid),
        .last_pix  (last_pix)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            idle_cnt_q   <= '0;
            kernel_we_q  <= 1'b0;
            pixel_we_q   <= 1'b0;
            send_we_q    <= 1'b0;
            frame_done_q <= 1'b0;
            overrun_q    <= 1'b0;
            out_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            idle_cnt_q   <= idle_cnt_d;
            kernel_we_q  <= kernel_we_d;
            pixel_we_q   <= pixel_we_d;
            send_we_q    <= send_we_d;
            frame_done_q <= frame_done_d;
            overrun_q    <= overrun_d;
            out_cnt_q    <= out_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        idle_cnt_d = '0;

        case (state_q)
            ST_IDLE: begin
                // Any low sample restarts the idle-line run.
                if (rx) begin
                    if (idle_cnt_q == c_idle_last) begin
                        state_d = ST_KERNEL;
                    end else begin
                        idle_cnt_d = idle_cnt_q + IDLE_W'(1);
                    end
                end
            end
            ST_KERNEL: begin
                if (kernel_done) begin
                    state_d = ST_PIXEL;
                end
            end
            ST_PIXEL: begin
                if (pix_accept && last_pix) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // The final window's strobe may still be in its register.
                if (!send_busy && !send_we_q) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_DONE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Enables are registered from the next state so they line up with it.
        kernel_we_d  = (state_d == ST_KERNEL);
        pixel_we_d   = (state_d == ST_PIXEL);
        send_we_d    = pix_accept && win_valid;
        frame_done_d = frame_done_q || (state_d == ST_DONE);
        // The strobe is not suppressed; the sender decides whether to drop it.
        overrun_d    = overrun_q || (send_we_q && send_busy);
        out_cnt_d    = out_cnt_q + 32'(send_we_q);
    end

    assign kernel_we  = kernel_we_q;
    assign pixel_we   = pixel_we_q;
    assign cal_we     = pix_accept;
    assign send_we    = send_we_q;
    assign frame_done = frame_done_q;
    assign overrun    = overrun_q;
    assign state      = state_q;

endmodule
`default_nettype wire

// File: tb/tb_conv_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_conv_frame_ctrl
// Description : Self-checking bench for conv_frame_ctrl on a 5x4 image with
//               a 3x3 kernel. Random pixel spacing, random rx glitches and
//               random sender busy are checked against a raster-position
//               model of which pixels close a complete window.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_conv_frame_ctrl;

    localparam int unsigned IMG_W    = 5;
    localparam int unsigned IMG_H    = 4;
    localparam int unsigned K        = 3;
    localparam int unsigned IDLE_CYC = 4;
    localparam int          NPIX     = IMG_W * IMG_H;
    localparam int          NOUT     = (IMG_W - K + 1) * (IMG_H - K + 1);

    localparam int S_IDLE = 0, S_KERNEL = 1, S_PIXEL = 2, S_DRAIN = 3, S_DONE = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic       kernel_done;
    logic       pix_valid;
    logic       send_busy;
    logic       kernel_we;
    logic       pixel_we;
    logic       cal_we;
    logic       send_we;
    logic       frame_done;
    logic       overrun;
    logic [2:0] state;

    int n_tests = 0;
    int n_fail  = 0;
    int cal_cnt = 0;
    int send_cnt = 0;

    // Reference model state
    int n_acc;       // pixels accepted in the current frame
    int exp_state;
    bit exp_ovr;

    conv_frame_ctrl #(
        .IMG_W    (IMG_W),
        .IMG_H    (IMG_H),
        .K        (K),
        .IDLE_CYC (IDLE_CYC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rx          (rx),
        .kernel_done (kernel_done),
        .pix_valid   (pix_valid),
        .send_busy   (send_busy),
        .kernel_we   (kernel_we),
        .pixel_we    (pixel_we),
        .cal_we      (cal_we),
        .send_we     (send_we),
        .frame_done  (frame_done),
        .overrun     (overrun),
        .state       (state)
    );

    always #5 clk = ~clk;

    // Strobe counters sampled mid-cycle.
    always begin
        @(negedge clk);
        #2;
        if (cal_we === 1'b1)  cal_cnt++;
        if (send_we === 1'b1) send_cnt++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_state"},      32'(state),      0);
        check({tag, "_kernel_we"},  32'(kernel_we),  0);
        check({tag, "_pixel_we"},   32'(pixel_we),   0);
        check({tag, "_cal_we"},     32'(cal_we),     0);
        check({tag, "_send_we"},    32'(send_we),    0);
        check({tag, "_frame_done"}, 32'(frame_done), 0);
        check({tag, "_overrun"},    32'(overrun),    0);
    endtask

    // One pix_valid pulse followed by 'gap' quiet cycles. in_pixel says
    // whether the model expects the DUT to be accepting pixels.
    task automatic pulse_pix(input bit in_pixel, input int gap, input bit busy);
        int r, c;
        bit exp_v;
        r     = n_acc / IMG_W;
        c     = n_acc % IMG_W;
        exp_v = in_pixel && (r >= K - 1) && (c >= K - 1);
        @(negedge clk);
        pix_valid = 1'b1;
        #1;
        check("cal_we", 32'(cal_we), 32'(in_pixel));
        @(negedge clk);
        pix_valid = 1'b0;
        send_busy = busy;
        check("send_we_after_pix", 32'(send_we), 32'(exp_v));
        if (in_pixel) begin
            n_acc++;
            if (n_acc == NPIX) exp_state = S_DRAIN;
        end
        if (exp_v && busy) exp_ovr = 1'b1;
        check("state_after_pix", 32'(state), 32'(exp_state));
        for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            check("send_we_gap", 32'(send_we), 0);
            check("overrun_gap", 32'(overrun), 32'(exp_ovr));
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        rx = 1'b0; kernel_done = 1'b0; pix_valid = 1'b0; send_busy = 1'b0;
        @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        n_acc = 0; exp_state = S_IDLE; exp_ovr = 1'b0;
    endtask

    // Random rx with glitches until the model sees IDLE_CYC consecutive highs.
    task automatic arm_random();
        int run = 0;
        bit v;
        for (int i = 0; i < 200 && run < IDLE_CYC; i++) begin
            @(negedge clk);
            v  = (i > 40) ? 1'b1 : ($urandom_range(0, 3) != 0);
            rx = v;
            run = v ? run + 1 : 0;
            @(posedge clk);
            #1;
            check("arm_state", 32'(state), (run >= IDLE_CYC) ? S_KERNEL : S_IDLE);
        end
        exp_state = S_KERNEL;
    endtask

    task automatic enter_pixel();
        @(negedge clk);
        check("kernel_we_hold", 32'(kernel_we), 1);
        check("kernel_state",   32'(state),     S_KERNEL);
        kernel_done = 1'b1;
        @(negedge clk);
        kernel_done = 1'b0;
        check("pixel_state",   32'(state),     S_PIXEL);
        check("pixel_we_on",   32'(pixel_we),  1);
        check("kernel_we_off", 32'(kernel_we), 0);
        exp_state = S_PIXEL;
    endtask

    task automatic run_pixels(input int npix, input bit rand_busy, input bit last_busy);
        bit last, busy;
        int gap;
        for (int n = 0; n < npix; n++) begin
            last = (n_acc == NPIX - 1);
            busy = last ? last_busy : (rand_busy ? 1'($urandom_range(0, 1)) : 1'b0);
            gap  = last ? 0 : int'($urandom_range(1, 3));
            pulse_pix(1'b1, gap, busy);
            if (n == 8) begin
                // Stray kernel_done while receiving pixels.
                @(negedge clk);
                kernel_done = 1'b1;
                @(negedge clk);
                kernel_done = 1'b0;
                check("stray_kdone_state", 32'(state), S_PIXEL);
            end
        end
    endtask

    task automatic wait_done();
        for (int i = 0; i < 20 && state !== 3'(S_DONE); i++) @(negedge clk);
        check("done_state",     32'(state),      S_DONE);
        check("frame_done",     32'(frame_done), 1);
        check("pixel_we_drain", 32'(pixel_we),   0);
        exp_state = S_DONE;
    endtask

    initial begin
        int c0, s0;
        bit pat [8];
        int run;

        rst = 1'b0; rx = 1'b0; kernel_done = 1'b0; pix_valid = 1'b0; send_busy = 1'b0;
        n_acc = 0; exp_state = S_IDLE; exp_ovr = 1'b0;
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        check_all_zero("por");
        rst = 1'b0;

        // Stray pixel in IDLE.
        pulse_pix(1'b0, 1, 1'b0);

        // Idle detect: 3 highs, a low, then 4 highs.
        pat = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        run = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            rx  = pat[i];
            run = pat[i] ? run + 1 : 0;
            @(posedge clk);
            #1;
            check("idle_state", 32'(state), (run >= IDLE_CYC) ? S_KERNEL : S_IDLE);
        end
        exp_state = S_KERNEL;

        // Stray pixels in KERNEL.
        pulse_pix(1'b0, 1, 1'b0);
        pulse_pix(1'b0, 2, 1'b0);

        // Frame 1: sender always idle.
        enter_pixel();
        c0 = cal_cnt; s0 = send_cnt;
        run_pixels(NPIX, 1'b0, 1'b0);
        wait_done();
        check("f1_overrun", 32'(overrun),         0);
        check("f1_cal_cnt", 32'(cal_cnt - c0),    NPIX);
        check("f1_send_cnt", 32'(send_cnt - s0),  NOUT);

        // Frame 2: aborted by reset after pixel 7.
        do_reset();
        arm_random();
        enter_pixel();
        run_pixels(7, 1'b0, 1'b0);
        #3;
        rst = 1'b1;
        pix_valid = 1'b1;
        #1;
        check_all_zero("midrst");
        @(negedge clk);
        pix_valid = 1'b0;
        rst = 1'b0;
        rx = 1'b0;
        n_acc = 0; exp_state = S_IDLE; exp_ovr = 1'b0;

        // Frame 3: random sender busy, busy held over the last pixel.
        arm_random();
        enter_pixel();
        c0 = cal_cnt; s0 = send_cnt;
        run_pixels(NPIX, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("drain_hold_state", 32'(state),   S_DRAIN);
            check("drain_overrun",    32'(overrun), 1);
        end
        send_busy = 1'b0;
        wait_done();
        check("f3_overrun_sticky", 32'(overrun),        1);
        check("f3_cal_cnt",        32'(cal_cnt - c0),   NPIX);
        check("f3_send_cnt",       32'(send_cnt - s0),  NOUT);

        // Pixels after DONE are ignored.
        pulse_pix(1'b0, 1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
